status_register: RTL

Holds the architectural NZCV flags and is the producer for the ID-stage condition checker. Each cycle it takes the EXE-stage ALU result, carry-out and operand sign bits. It computes the next N, Z, C and V per ALU command and commits them when the instruction has its S bit set. The registered 4-bit status vector feeds the condition checker's z, c, n, v inputs.

---
 rtl/status_register.sv | 139 +++++++++++++
 1 files changed

// File: rtl/status_register.sv
// status_register: architectural NZCV flag register feeding the ID-stage
// condition checker. Flags are computed from the EXE-stage ALU outputs and
// committed when a valid, non-stalled, non-flushed S-bit instruction issues
// a flag-affecting ALU command.
// Optional feature: define STATUS_FWD_EN to forward the committing flags
// combinationally onto status in the same cycle.
module status_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exe_valid,
  input  logic             s_bit,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             op1_msb,
  input  logic             op2_msb,
  input  logic             freeze,
  input  logic             flush,
  output logic [3:0]       status,
  output logic             status_wr
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  // Signed overflow. Operand 2's sign is taken before inversion, so for
  // subtraction overflow needs differing operand signs rather than equal ones.
  function automatic logic calc_overflow(
    input logic is_sub,
    input logic a_msb,
    input logic b_msb,
    input logic res_msb
  );
    logic signs_ok;
    signs_ok = is_sub ? (a_msb != b_msb) : (a_msb == b_msb);
    return signs_ok & (res_msb != a_msb);
  endfunction

  logic [3:0] status_r;
  logic       status_wr_r;
  logic       is_arith_s;
  logic       is_logic_s;
  logic       is_sub_s;
  logic       commit_s;
  logic       n_s;
  logic       z_s;
  logic       c_s;
  logic       v_s;
  logic [3:0] next_flags_s;

  // Classify the ALU command into arithmetic, logical or no-flag groups.
  always_comb begin
    is_arith_s = 1'b0;
    is_logic_s = 1'b0;
    is_sub_s   = 1'b0;
    case (exe_cmd)
      CMD_ADD, CMD_ADC: begin
        is_arith_s = 1'b1;
      end
      CMD_SUB, CMD_SBC: begin
        is_arith_s = 1'b1;
        is_sub_s   = 1'b1;
      end
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: begin
        is_logic_s = 1'b1;
      end
      default: begin
        is_arith_s = 1'b0;
        is_logic_s = 1'b0;
        is_sub_s   = 1'b0;
      end
    endcase
  end

  // Build next NZCV; logical ops carry C and V over from the current flags.
  always_comb begin
    n_s = alu_result[WIDTH-1];
    z_s = (alu_result == {WIDTH{1'b0}});
    if (is_arith_s) begin
      c_s = alu_cout;
      v_s = calc_overflow(is_sub_s, op1_msb, op2_msb, n_s);
    end else begin
      c_s = status_r[1];
      v_s = status_r[0];
    end
    next_flags_s = {n_s, z_s, c_s, v_s};
  end

  // A commit needs a real, flag-affecting S instruction that is neither stalled nor flushed.
  always_comb begin
    commit_s = exe_valid & s_bit & ~freeze & ~flush & (is_arith_s | is_logic_s);
  end

  // Flag register and one-cycle write strobe; reset overrides any pending commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_r    <= 4'b0000;
      status_wr_r <= 1'b0;
    end else begin
      status_wr_r <= commit_s;
      if (commit_s) begin
        status_r <= next_flags_s;
      end else begin
        status_r <= status_r;
      end
    end
  end

`ifdef STATUS_FWD_EN
  // Forward the committing flags so the condition checker sees them this cycle.
  always_comb begin
    if (commit_s) begin
      status = next_flags_s;
    end else begin
      status = status_r;
    end
  end
`else
  // Status comes straight from the flag flops.
  always_comb begin
    status = status_r;
  end
`endif

  // Write strobe comes straight from its flop.
  always_comb begin
    status_wr = status_wr_r;
  end

endmodule
